// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: word bus with byte enables, ack timeout, load extension.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        lsu_stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    localparam logic [7:0] TimeoutCnt = ACK_TIMEOUT[7:0];

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        legal, misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata_rep, load_ext;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        if (req_we) begin
            legal = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2);
        end else begin
            legal = (req_funct3 != 3'd3) && (req_funct3 != 3'd6) && (req_funct3 != 3'd7);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        // funct3[1:0] encodes width for both signed and unsigned variants
        case (req_funct3[1:0])
            2'd0: begin
                req_be        = 4'b0001 << req_addr[1:0];
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                req_be        = 4'b1111;
                req_wdata_rep = req_wdata;
            end
        endcase
    end

    always_comb begin
        lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'd0:    load_ext = {{24{lane_b[7]}}, lane_b};
            3'd4:    load_ext = {24'b0, lane_b};
            3'd1:    load_ext = {{16{lane_h[15]}}, lane_h};
            3'd5:    load_ext = {16'b0, lane_h};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    be_d     = req_be;
                    wdata_d  = req_wdata_rep;
                    cnt_d    = 8'd0;
                    if (!legal || misaligned) begin
                        state_d = StResp;
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StBus;
                    end
                end
            end
            StBus: begin
                // Ack takes priority over a timeout expiring in the same cycle
                if (mem_ack) begin
                    state_d = StResp;
                    rdata_d = we_q ? 32'd0 : load_ext;
                    err_d   = 1'b0;
                end else if ((TimeoutCnt != 8'd0) && (cnt_q == TimeoutCnt - 8'd1)) begin
                    state_d = StResp;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else if (TimeoutCnt != 8'd0) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign lsu_stall = ((state_q == StIdle) && req_valid) || (state_q == StBus);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_req   = (state_q == StBus);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level model, per-cycle compare, random traffic.
// Misalignment expectations follow LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        lsu_stall, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    load_store_unit #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .lsu_stall(lsu_stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected per-cycle view, updated by the driver just after each rising edge
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_rsp_valid = 1'b0, exp_err = 1'b0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_rdata = 32'd0, exp_addr = 32'd0, exp_wdata = 32'd0;
    logic [3:0]  exp_be = 4'd0;

    int          stall_cnt = 0, req_cnt = 0;
    logic [31:0] last_addr = 32'd0, last_wdata = 32'd0;
    logic [3:0]  last_be = 4'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic m_legal(input logic we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    function automatic logic m_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (f3 == 3'd1 || f3 == 3'd5) return a[0];
        if (f3 == 3'd2) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (f3 == 3'd0 || f3 == 3'd4) return 4'(1 << off);
        if (f3 == 3'd1 || f3 == 3'd5) return (off >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return {4{d[7:0]}};
        if (f3 == 3'd1) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint v;
        int     off;
        case (f3)
            3'd0, 3'd4: begin
                off = int'(a[1:0]);
                v = longint'((rd >> (8 * off)) & 32'hFF);
                if (f3 == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                off = a[1] ? 2 : 0;
                v = longint'((rd >> (8 * off)) & 32'hFFFF);
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(rd);
        endcase
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("lsu_stall", 32'(lsu_stall), 32'(exp_stall));
            check("mem_req", 32'(mem_req), 32'(exp_req));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            check("rsp_rdata", rsp_rdata, exp_rdata);
            check("rsp_err", 32'(rsp_err), 32'(exp_err));
            if (exp_req) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_be", 32'(mem_be), 32'(exp_be));
                check("mem_we", 32'(mem_we), 32'(exp_we));
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (lsu_stall) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                last_addr  = mem_addr;
                last_be    = mem_be;
                last_wdata = mem_wdata;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            exp_stall = 1'b0; exp_req = 1'b0; exp_rsp_valid = 1'b0;
        end
    endtask

    // One access; w = wait cycles before ack (w >= TO means the slave never acks)
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd, input int w);
        logic        bad, tmo;
        int          n;
        logic [31:0] rx;
        bad = !m_legal(we, f3) || m_misaligned(f3, a);
        tmo = !bad && (w >= TO);
        n = (w >= TO) ? TO : w + 1;
        rx = (bad || tmo || we) ? 32'd0 : m_load(f3, a, rd);
        stall_cnt = 0;
        req_cnt = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        exp_stall = 1'b1; exp_req = 1'b0; exp_rsp_valid = 1'b0;
        if (!bad) begin
            exp_we = we;
            exp_addr = {a[31:2], 2'b00};
            exp_be = m_be(f3, a);
            exp_wdata = m_wdata(f3, d);
            for (int i = 0; i < n; i++) begin
                @(posedge clk); #1;
                exp_req = 1'b1;
                mem_ack = (i == w);
                mem_rdata = (i == w) ? rd : $urandom;
            end
        end
        @(posedge clk); #1;
        // req_valid stays high in RESP: it still describes the completing instruction
        exp_stall = 1'b0; exp_req = 1'b0; exp_rsp_valid = 1'b1;
        exp_rdata = rx; exp_err = bad || tmo;
        mem_ack = tmo ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;
        #3;
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset lsu_stall", 32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        do_txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        check("sw be", 32'(last_be), 32'hF);
        check("sw addr", last_addr, 32'h100);
        check("sw wdata", last_wdata, 32'hDEADBEEF);
        check("sw stall cycles", 32'(stall_cnt), 32'd2);
        check("sw rdata", rsp_rdata, 32'd0);
        idle(1);

        do_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 3);
        check("lb be", 32'(last_be), 32'h8);
        check("lb rdata", rsp_rdata, 32'hFFFFFF80);
        check("lb stall cycles", 32'(stall_cnt), 32'd5);
        do_txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 1);
        check("lbu rdata", rsp_rdata, 32'h00000080);

        do_txn(1'b1, 3'd1, 32'h002, 32'h0000ABCD, 32'h0, 0);
        check("sh be", 32'(last_be), 32'hC);
        check("sh wdata", last_wdata, 32'hABCDABCD);

        do_txn(1'b0, 3'd2, 32'h10, 32'h0, 32'h0, 10);
        check("timeout req cycles", 32'(req_cnt), 32'(TO));
        check("timeout err", 32'(rsp_err), 32'd1);
        idle(3);

        do_txn(1'b0, 3'd2, 32'h6, 32'h0, 32'h12345678, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw misaligned req cycles", 32'(req_cnt), 32'd0);
        check("lw misaligned err", 32'(rsp_err), 32'd1);
`else
        check("lw unaligned addr", last_addr, 32'h4);
        check("lw unaligned be", 32'(last_be), 32'hF);
        check("lw unaligned rdata", rsp_rdata, 32'h12345678);
`endif
        do_txn(1'b0, 3'd3, 32'h20, 32'h0, 32'h0, 0);
        check("illegal req cycles", 32'(req_cnt), 32'd0);
        check("illegal err", 32'(rsp_err), 32'd1);

        do_txn(1'b0, 3'd1, 32'h002, 32'h0, 32'h80015555, 0);
        check("lh rdata", rsp_rdata, 32'hFFFF8001);

        // Reset in the second BUS wait cycle of a load
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
        mem_ack = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_rsp_valid = 1'b0;
        exp_we = 1'b0; exp_addr = 32'h40; exp_be = 4'hF;
        @(posedge clk); #1;
        exp_req = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1; req_valid = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_rdata = 32'd0; exp_err = 1'b0;
        #1;
        check("async reset mem_req", 32'(mem_req), 32'd0);
        check("async reset lsu_stall", 32'(lsu_stall), 32'd0);
        check("async reset rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_txn(1'b0, 3'd2, 32'h80, 32'h0, 32'hCAFEF00D, 0);
        check("post-reset lw stall cycles", 32'(stall_cnt), 32'd2);
        check("post-reset lw rdata", rsp_rdata, 32'hCAFEF00D);

        for (int k = 0; k < 300; k++) begin
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, int'($urandom_range(0, 6)));
            idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
